// File: rtl/phase_a_pkg.sv
// Shared definitions for the phase_a sequencer: operand widths, FSM state
// encoding and the operand bundle held stable across a job.
package phase_a_pkg;

    localparam int WIDTH    = 3072;
    localparam int MN_WIDTH = 3074;
    localparam int MP_WIDTH = 56;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // a is the running operand; m, m_n, m_prime are frozen for the job
    typedef struct packed {
        logic [WIDTH-1:0]    a;
        logic [WIDTH-1:0]    m;
        logic [MN_WIDTH-1:0] m_n;
        logic [MP_WIDTH-1:0] m_prime;
    } operand_t;

endpackage

// File: rtl/phase_a_ctrl.sv
// Sequencer for one phase_a Montgomery-step datapath. Latches the start
// operand and modulus constants, issues n_iter back-to-back phase_a passes
// feeding new_a back as a, then returns the final operand with a done pulse.
// Optional watchdog on the WAIT state: define PHASE_A_CTRL_TIMEOUT_EN.
module phase_a_ctrl #(
    parameter int WIDTH     = 3072,
    parameter int MN_WIDTH  = 3074,
    parameter int MP_WIDTH  = 56,
    parameter int CNT_WIDTH = 12,
    parameter int TIMEOUT   = 4095
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CNT_WIDTH-1:0] n_iter,
    input  logic [WIDTH-1:0]     a_init,
    input  logic [WIDTH-1:0]     m_in,
    input  logic [MN_WIDTH-1:0]  m_n_in,
    input  logic [MP_WIDTH-1:0]  m_prime_in,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [WIDTH-1:0]     result,
    output logic                 pa_en,
    output logic [WIDTH-1:0]     pa_a,
    output logic [WIDTH-1:0]     pa_m,
    output logic [MN_WIDTH-1:0]  pa_m_n,
    output logic [MP_WIDTH-1:0]  pa_m_prime,
    input  logic [WIDTH-1:0]     pa_new_a,
    input  logic                 pa_en_out
);

    import phase_a_pkg::*;

    state_t               state, state_nxt;
    operand_t             opnd;
    logic [CNT_WIDTH-1:0] remaining;
    logic                 launch, accept;

    // A job launches only from IDLE; abort beats start there
    assign launch = (state == IDLE) && start && !abort;
    // Responses count only while waiting; ISSUE-cycle responses are too early
    assign accept = (state == WAIT) && pa_en_out && !abort;

    assign pa_a       = opnd.a;
    assign pa_m       = opnd.m;
    assign pa_m_n     = opnd.m_n;
    assign pa_m_prime = opnd.m_prime;

`ifdef PHASE_A_CTRL_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wdog;
    logic            wd_fire;
    logic            err_q;

    assign wd_fire = (state == WAIT) && !pa_en_out && !abort &&
                     (wdog == WD_W'(TIMEOUT - 1));
    assign err     = err_q;

    // Watchdog: zero outside WAIT so it restarts on every WAIT entry
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog  <= '0;
            err_q <= 1'b0;
        end else begin
            wdog  <= (state == WAIT) ? wdog + WD_W'(1) : '0;
            err_q <= wd_fire;
        end
    end
`else
    assign err = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and strobe outputs; abort overrides everything off-IDLE
    always_comb begin
        state_nxt = state;
        pa_en     = 1'b0;
        done      = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (launch) state_nxt = (n_iter == '0) ? DONE : ISSUE;
            end
            ISSUE: begin
                pa_en     = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (pa_en_out)
                    state_nxt = (remaining == CNT_WIDTH'(1)) ? DONE : ISSUE;
`ifdef PHASE_A_CTRL_TIMEOUT_EN
                else if (wd_fire)
                    state_nxt = IDLE;
`endif
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (abort && state != IDLE) begin
            state_nxt = IDLE;
            pa_en     = 1'b0;
            done      = 1'b0;
        end
    end

    // Operand latch and pass counter; constants frozen from launch to launch
    always_ff @(posedge clk) begin
        if (rst) begin
            opnd      <= '0;
            remaining <= '0;
        end else if (launch) begin
            opnd.a       <= a_init;
            opnd.m       <= m_in;
            opnd.m_n     <= m_n_in;
            opnd.m_prime <= m_prime_in;
            remaining    <= n_iter;
        end else if (accept) begin
            opnd.a    <= pa_new_a;
            remaining <= remaining - CNT_WIDTH'(1);
        end
    end

    // Result register: written only by a DONE cycle that is not aborted
    always_ff @(posedge clk) begin
        if (rst)                          result <= '0;
        else if (state == DONE && !abort) result <= opnd.a;
    end

endmodule

// File: doc/phase_a_ctrl.md
Name: phase_a_ctrl

Overview:
- Sequencer for one `phase_a` Montgomery-step datapath in the 3072-bit RSA engine.
- Latches a start operand and the modulus constants (m, m_n, m_prime), then issues N back-to-back `phase_a` passes.
- Feeds each `new_a` back as the next `a` and returns the final value with a done pulse.
- Holds all datapath inputs stable for the whole job, so upstream logic may change its buses freely after start.

Parameters:
- WIDTH, 3072, operand and modulus width
- MN_WIDTH, 3074, width of m_n
- MP_WIDTH, 56, width of m_prime
- CNT_WIDTH, 12, width of the iteration count
- TIMEOUT, 4095, watchdog limit in cycles (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  job request; sampled only in IDLE
- abort  in  1  synchronous job cancel
- n_iter  in  CNT_WIDTH  number of phase_a passes
- a_init  in  WIDTH  initial operand
- m_in  in  WIDTH  modulus
- m_n_in  in  MN_WIDTH  modulus-derived constant
- m_prime_in  in  MP_WIDTH  Montgomery constant
- busy  out  1  job in progress
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle timeout pulse
- result  out  WIDTH  final operand
- pa_en  out  1  phase_a enable pulse
- pa_a  out  WIDTH  phase_a operand
- pa_m  out  WIDTH  phase_a modulus
- pa_m_n  out  MN_WIDTH  phase_a m_n
- pa_m_prime  out  MP_WIDTH  phase_a m_prime
- pa_new_a  in  WIDTH  phase_a result
- pa_en_out  in  1  phase_a result-valid pulse

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; work, remaining and watchdog registers 0.
- FSM has four states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - start=1 latches a_init→work, m_in/m_n_in/m_prime_in→pa_m/pa_m_n/pa_m_prime, and n_iter→remaining.
  - If n_iter≠0, go to ISSUE; if n_iter=0, go to DONE with result=a_init.
  - start in any other state is ignored.
- ISSUE:
  - pa_en=1 for exactly this one cycle; pa_a=work (pa_a follows work in every state).
  - Next state is WAIT.
- WAIT:
  - pa_en=0.
  - On pa_en_out=1: work←pa_new_a, remaining←remaining−1.
  - If remaining was 1, go to DONE; otherwise go to ISSUE next cycle.
  - pa_en_out sampled in the same cycle as pa_en (i.e. zero-latency response) is not accepted. It is legal only in WAIT and is ignored in IDLE, ISSUE and DONE.
- DONE:
  - result←work; done=1 for one cycle; then IDLE.
  - result holds until the next job completes.
- busy=1 in ISSUE, WAIT and DONE; busy=0 in IDLE.
- Cycle cost: each pass costs 1 + L cycles, where L is the phase_a latency from pa_en to pa_en_out (L≥1).
- abort=1 in any non-IDLE state:
  - Next state is IDLE; pa_en=0, done=0; result unchanged.
  - An in-flight pa_en_out arriving later is ignored.
- If start and abort are both high in IDLE, abort wins and the job is not started.
- rst=1 mid-job has the same effect as the reset values above; result clears to 0.
- Arithmetic: remaining is a pure down-counter; there is no wrap, and n_iter=2^CNT_WIDTH−1 is legal.

Optional Feature:
- Macro: PHASE_A_CTRL_TIMEOUT_EN.
- With it defined:
  - A watchdog counts cycles spent in WAIT and clears on entry to WAIT.
  - If it reaches TIMEOUT without pa_en_out, the FSM goes to IDLE, err=1 for one cycle, no done, result unchanged.
- Without it: WAIT waits indefinitely and err is tied to 0.

Decomposition:
- Shared package phase_a_pkg holds:
  - the width constants WIDTH, MN_WIDTH, MP_WIDTH;
  - the FSM state enum (IDLE/ISSUE/WAIT/DONE), 2-bit encoding;
  - an operand-bundle typedef {a, m, m_n, m_prime}.
- No sub-module: operand latch, counter and FSM stay in one module. The bench instantiates real phase_a or a stub.

Test Plan:
- Stub new_a=a+1, pa_en_out three cycles after pa_en; a_init=5, n_iter=4, start at cycle 0 → pa_en at cycles 1,5,9,13; done=1 at cycle 17; result=9; busy high for cycles 1–17.
- n_iter=0, a_init=0xABC → no pa_en, done at cycle 1, result=0xABC.
- Start with n_iter=3; drive m_in=0 one cycle after start → pa_m stays at the latched value throughout; a second start in WAIT is ignored.
- abort in WAIT of pass 2, with stub pa_en_out arriving afterwards → IDLE next cycle, no done, result keeps the previous value; a new job then completes normally.
- rst pulsed in ISSUE → all outputs 0 next cycle; start then accepted.
- With PHASE_A_CTRL_TIMEOUT_EN and TIMEOUT=8, stub never responds → err pulses exactly 8 cycles after WAIT entry, busy=0, done never asserted.
